// File: rtl/mem_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : custom_types_pkg
//  Description : Shared types and default sizing for the memory bus arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package custom_types_pkg;

    localparam int CACHE_W   = 2;
    localparam int ARB_NREQ  = CACHE_W;
    localparam int ARB_BURST = 2;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_XFER = 2'd1,
        ARB_DONE = 2'd2
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/mem_bus_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
//  Module      : rr_picker
//  Description : Combinational rotate-priority selector; the first set bit of
//                i_req at or after i_ptr (wrapping modulo NREQ) wins.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_picker #(
    parameter int NREQ  = 2,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic             o_valid,
    output logic [IDX_W-1:0] o_idx
);

    localparam int SUM_W = IDX_W + 1;

    logic [2*NREQ-1:0] w_dbl;
    logic [NREQ-1:0]   w_rot;
    logic [SUM_W-1:0]  w_off;
    logic [SUM_W-1:0]  w_sum;

    // Rotating a doubled copy puts requester i_ptr at bit 0 without any
    // power-of-two assumption on NREQ.
    assign w_dbl = {i_req, i_req} >> i_ptr;
    assign w_rot = w_dbl[NREQ-1:0];

    always_comb begin
        w_off = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = SUM_W'(k);
            end
        end
    end

    assign w_sum   = {1'b0, i_ptr} + w_off;
    assign o_valid = |i_req;
    assign o_idx   = (w_sum >= SUM_W'(NREQ)) ? IDX_W'(w_sum - SUM_W'(NREQ))
                                             : w_sum[IDX_W-1:0];

endmodule
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_bus_arbiter
//  Description : Round-robin arbiter of NREQ cache channels onto one RAM port,
//                holding each grant for a BURST_LEN-word block transfer.
//                Optional MEM_BUS_ARB_WRITE_PRIO_EN: pending writes win over
//                reads (round-robin within writers).
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter
    import custom_types_pkg::*;
#(
    parameter int NREQ      = ARB_NREQ,
    parameter int BURST_LEN = ARB_BURST,
    parameter int IDX_W     = $clog2(NREQ)
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ-1:0]    req_write,
    input  logic [NREQ*32-1:0] req_addr,
    input  logic [NREQ*32-1:0] req_wdata,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    rvalid,
    output logic [NREQ-1:0]    wready,
    output logic [NREQ-1:0]    done,
    output logic [31:0]        rdata,
    output logic               ramREN,
    output logic               ramWEN,
    output logic [31:0]        ramaddr,
    output logic [31:0]        ramstore,
    input  logic [31:0]        ramload,
    input  ramstate_t          ramstate
);

    localparam int BEAT_W = $clog2(BURST_LEN + 1);

    arb_state_t         r_state;
    logic [IDX_W-1:0]   r_owner;
    logic [BEAT_W-1:0]  r_beat;
    logic [31:0]        r_base;
    logic               r_wr;
    logic [IDX_W-1:0]   r_rr_ptr;

    logic [31:0]        w_addr  [NREQ];
    logic [31:0]        w_wdata [NREQ];
    logic               w_pick_valid;
    logic [IDX_W-1:0]   w_pick_idx;

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign w_addr[g]  = req_addr[g*32 +: 32];
        assign w_wdata[g] = req_wdata[g*32 +: 32];
    end

`ifdef MEM_BUS_ARB_WRITE_PRIO_EN
    logic               w_wr_valid;
    logic [IDX_W-1:0]   w_wr_idx;
    logic               w_any_valid;
    logic [IDX_W-1:0]   w_any_idx;

    rr_picker #(.NREQ(NREQ), .IDX_W(IDX_W)) u_pick_wr (
        .i_req   (req_valid & req_write),
        .i_ptr   (r_rr_ptr),
        .o_valid (w_wr_valid),
        .o_idx   (w_wr_idx)
    );

    rr_picker #(.NREQ(NREQ), .IDX_W(IDX_W)) u_pick_any (
        .i_req   (req_valid),
        .i_ptr   (r_rr_ptr),
        .o_valid (w_any_valid),
        .o_idx   (w_any_idx)
    );

    assign w_pick_valid = w_any_valid;
    assign w_pick_idx   = w_wr_valid ? w_wr_idx : w_any_idx;
`else
    rr_picker #(.NREQ(NREQ), .IDX_W(IDX_W)) u_pick_any (
        .i_req   (req_valid),
        .i_ptr   (r_rr_ptr),
        .o_valid (w_pick_valid),
        .o_idx   (w_pick_idx)
    );
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state  <= ARB_IDLE;
            r_owner  <= '0;
            r_beat   <= '0;
            r_base   <= '0;
            r_wr     <= 1'b0;
            r_rr_ptr <= '0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_pick_valid) begin
                        r_owner <= w_pick_idx;
                        r_base  <= w_addr[w_pick_idx];
                        r_wr    <= req_write[w_pick_idx];
                        r_beat  <= '0;
                        r_state <= ARB_XFER;
                    end
                end
                ARB_XFER: begin
                    // BUSY/FREE stall; ERROR retries the same beat.
                    if (ramstate == ACCESS) begin
                        r_beat <= r_beat + 1'b1;
                        if (r_beat == BEAT_W'(BURST_LEN - 1)) begin
                            r_state <= ARB_DONE;
                        end
                    end
                end
                ARB_DONE: begin
                    r_rr_ptr <= (r_owner == IDX_W'(NREQ - 1)) ? '0 : r_owner + 1'b1;
                    r_state  <= ARB_IDLE;
                end
                default: begin
                    r_state <= ARB_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        gnt      = '0;
        rvalid   = '0;
        wready   = '0;
        done     = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        case (r_state)
            ARB_XFER: begin
                gnt[r_owner] = 1'b1;
                ramREN       = ~r_wr;
                ramWEN       = r_wr;
                ramaddr      = r_base + (32'(r_beat) << 2);
                ramstore     = w_wdata[r_owner];
                if (ramstate == ACCESS) begin
                    if (r_wr) begin
                        wready[r_owner] = 1'b1;
                    end else begin
                        rvalid[r_owner] = 1'b1;
                    end
                end
            end
            ARB_DONE: begin
                gnt[r_owner]  = 1'b1;
                done[r_owner] = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign rdata = ramload;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_bus_arbiter
//  Description : Directed bench for mem_bus_arbiter (NREQ=3, BURST_LEN=2)
//                with a transaction-level reference model checked each cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_bus_arbiter;
    import custom_types_pkg::*;

    localparam int NREQ = 3;
    localparam int BL   = 2;
`ifdef MEM_BUS_ARB_WRITE_PRIO_EN
    localparam int PRIO_WIN = 1;
`else
    localparam int PRIO_WIN = 0;
`endif

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [NREQ-1:0]    req_valid = '0;
    logic [NREQ-1:0]    req_write = '0;
    logic [NREQ*32-1:0] req_addr;
    logic [NREQ*32-1:0] req_wdata;
    logic [NREQ-1:0]    gnt, rvalid, wready, done;
    logic [31:0]        rdata, ramaddr, ramstore;
    logic               ramREN, ramWEN;
    logic [31:0]        ramload = '0;
    ramstate_t          ramstate = FREE;

    logic [31:0]        a_addr  [NREQ];
    logic [31:0]        a_wdata [NREQ];

    int n_vec = 0;
    int n_err = 0;

    for (genvar g = 0; g < NREQ; g++) begin : g_pack
        assign req_addr[g*32 +: 32]  = a_addr[g];
        assign req_wdata[g*32 +: 32] = a_wdata[g];
    end

    mem_bus_arbiter #(.NREQ(NREQ), .BURST_LEN(BL)) dut (
        .CLK       (clk),
        .RST       (rst),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .wready    (wready),
        .done      (done),
        .rdata     (rdata),
        .ramREN    (ramREN),
        .ramWEN    (ramWEN),
        .ramaddr   (ramaddr),
        .ramstore  (ramstore),
        .ramload   (ramload),
        .ramstate  (ramstate)
    );

    always #5 clk = ~clk;

    // Reference model: one transaction in flight, described by who owns it,
    // how many words have moved and whether it is in its closing cycle.
    bit          m_active = 0;
    bit          m_closing = 0;
    int          m_owner = 0;
    int          m_words = 0;
    int          m_ptr = 0;
    logic [31:0] m_base = '0;
    bit          m_wr = 0;

    function automatic int pick(input logic [NREQ-1:0] v, input logic [NREQ-1:0] w, input int ptr);
        int r;
        r = -1;
`ifdef MEM_BUS_ARB_WRITE_PRIO_EN
        for (int k = 0; k < NREQ; k++)
            if (r < 0 && v[(ptr + k) % NREQ] && w[(ptr + k) % NREQ]) r = (ptr + k) % NREQ;
`endif
        for (int k = 0; k < NREQ; k++)
            if (r < 0 && v[(ptr + k) % NREQ]) r = (ptr + k) % NREQ;
        return r;
    endfunction

    logic [NREQ-1:0] e_gnt, e_rv, e_wr, e_done;
    logic            e_ren, e_wen;
    logic [31:0]     e_addr, e_store;

    always @(negedge clk) begin
        int p;
        e_gnt = '0; e_rv = '0; e_wr = '0; e_done = '0;
        e_ren = 0; e_wen = 0; e_addr = '0; e_store = '0;
        if (!rst && m_active) begin
            e_gnt[m_owner] = 1'b1;
            if (m_closing) begin
                e_done[m_owner] = 1'b1;
            end else begin
                e_ren   = !m_wr;
                e_wen   = m_wr;
                e_addr  = m_base + 32'(4 * m_words);
                e_store = a_wdata[m_owner];
                if (ramstate == ACCESS) begin
                    if (m_wr) e_wr[m_owner] = 1'b1;
                    else      e_rv[m_owner] = 1'b1;
                end
            end
        end
        n_vec++;
        if (gnt !== e_gnt || rvalid !== e_rv || wready !== e_wr || done !== e_done ||
            ramREN !== e_ren || ramWEN !== e_wen || ramaddr !== e_addr ||
            ramstore !== e_store || rdata !== ramload) begin
            n_err++;
            $display("FAIL model t=%0t: gnt %b/%b rvalid %b/%b wready %b/%b done %b/%b ren %b/%b wen %b/%b addr %h/%h store %h/%h rdata %h/%h (got/exp)",
                     $time, gnt, e_gnt, rvalid, e_rv, wready, e_wr, done, e_done,
                     ramREN, e_ren, ramWEN, e_wen, ramaddr, e_addr, ramstore, e_store, rdata, ramload);
        end
        // advance the model to the state after the coming rising edge
        if (rst) begin
            m_active = 0; m_closing = 0; m_ptr = 0;
        end else if (!m_active) begin
            p = pick(req_valid, req_write, m_ptr);
            if (p >= 0) begin
                m_active = 1; m_owner = p; m_words = 0;
                m_base = a_addr[p]; m_wr = req_write[p];
            end
        end else if (m_closing) begin
            m_ptr = (m_owner + 1) % NREQ;
            m_active = 0; m_closing = 0;
        end else if (ramstate == ACCESS) begin
            m_words++;
            if (m_words == BL) m_closing = 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        ramload = $urandom;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int oh_idx(input logic [NREQ-1:0] v);
        int r;
        r = -1;
        for (int k = 0; k < NREQ; k++) if (v[k]) r = k;
        return r;
    endfunction

    initial begin
        int q[$];
        logic [NREQ-1:0] prev;
        bit found;
        for (int k = 0; k < NREQ; k++) begin a_addr[k] = '0; a_wdata[k] = '0; end

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_ren_wen", 32'({ramREN, ramWEN}), 32'h0);
        chk("rst_addr", ramaddr, 32'h0);
        tick();
        rst = 1'b0;
        tick();

        // single read from requester 1
        ramstate = ACCESS;
        a_addr[1] = 32'h100;
        req_valid = 3'b010;
        tick();
        req_valid = 3'b000;
        @(negedge clk); chk("rd_addr0", ramaddr, 32'h100); chk("rd_rvalid0", 32'(rvalid), 32'h2);
        tick();
        @(negedge clk); chk("rd_addr1", ramaddr, 32'h104); chk("rd_rvalid1", 32'(rvalid), 32'h2);
        tick();
        @(negedge clk); chk("rd_done", 32'(done), 32'h2); chk("rd_done_rv", 32'(rvalid), 32'h0);
        tick();
        @(negedge clk); chk("rd_idle_gnt", 32'(gnt), 32'h0);

        // write with BUSY/ERROR stalls and a mid-burst address change
        ramstate = BUSY;
        a_addr[0] = 32'h40; a_wdata[0] = 32'hA5A5_0001;
        req_write = 3'b001; req_valid = 3'b001;
        tick();
        req_valid = 3'b000; a_addr[0] = 32'h200;
        @(negedge clk); chk("wr_busy_addr", ramaddr, 32'h40); chk("wr_busy_wready", 32'(wready), 32'h0);
        chk("wr_wen", 32'(ramWEN), 32'h1);
        tick();
        ramstate = ERROR;
        @(negedge clk); chk("wr_err_addr", ramaddr, 32'h40); chk("wr_err_wready", 32'(wready), 32'h0);
        tick();
        ramstate = ACCESS;
        @(negedge clk); chk("wr_acc0", 32'(wready), 32'h1); chk("wr_acc0_addr", ramaddr, 32'h40);
        tick();
        a_wdata[0] = 32'hA5A5_0002;
        @(negedge clk); chk("wr_acc1_addr", ramaddr, 32'h44); chk("wr_store1", ramstore, 32'hA5A5_0002);
        tick();
        @(negedge clk); chk("wr_done", 32'(done), 32'h1);
        tick();
        req_write = 3'b000;

        // asynchronous reset in the middle of a burst
        ramstate = BUSY;
        a_addr[2] = 32'h300;
        req_valid = 3'b100;
        tick();
        req_valid = 3'b000;
        @(negedge clk); chk("pre_rst_ren", 32'(ramREN), 32'h1); chk("pre_rst_gnt", 32'(gnt), 32'h4);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_ren_wen", 32'({ramREN, ramWEN}), 32'h0);
        chk("rst_mid_pulses", 32'({gnt, rvalid, wready, done}), 32'h0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // reader 0 and writer 1 together, rr_ptr back at 0
        ramstate = ACCESS;
        a_addr[0] = 32'h500; a_addr[1] = 32'h600; a_wdata[1] = 32'h1111_2222;
        req_write = 3'b010; req_valid = 3'b011;
        tick();
        @(negedge clk); chk("prio_first_gnt", 32'(gnt), 32'(1 << PRIO_WIN));
        req_valid[PRIO_WIN] = 1'b0;
        found = 0;
        for (int c = 0; c < 16 && !found; c++) begin
            @(negedge clk);
            if (done[1 - PRIO_WIN]) found = 1;
        end
        chk("prio_loser_done", 32'(found), 32'h1);
        tick();
        req_valid = 3'b000; req_write = 3'b000;
        repeat (2) tick();

        // fairness: all three requesters held high from rr_ptr=0
        rst = 1'b1; tick(); tick(); rst = 1'b0; tick();
        a_addr[0] = 32'h1000; a_addr[1] = 32'h2000; a_addr[2] = 32'h3000;
        req_valid = 3'b111;
        prev = '0;
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            if (gnt != 0 && prev == 0) q.push_back(oh_idx(gnt));
            prev = gnt;
        end
        tick();
        req_valid = 3'b000;
        chk("fair_count_ge4", 32'(q.size() >= 4), 32'h1);
        if (q.size() >= 4)
            chk("fair_order", {8'(q[0]), 8'(q[1]), 8'(q[2]), 8'(q[3])}, 32'h0001_0200);
        repeat (8) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
